sobel_stream_ctrl: RTL

SOBEL_STREAM_CTRL -- requirements
Module: sobel_stream_ctrl

---
 rtl/image_pkg.sv | 27 ++
 rtl/line_buffer.sv | 26 ++
 rtl/sobel_stream_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/image_pkg.sv
// image_pkg: shared types and constants for the Sobel stream controller.
// Holds the FSM state enum, pixel width default and window slot indices.
package image_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int N_SLOTS   = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Row-major 3x3 window, slot 0 is top-left
  localparam int SLOT_TL = 0;
  localparam int SLOT_TC = 1;
  localparam int SLOT_TR = 2;
  localparam int SLOT_ML = 3;
  localparam int SLOT_MC = 4;
  localparam int SLOT_MR = 5;
  localparam int SLOT_BL = 6;
  localparam int SLOT_BC = 7;
  localparam int SLOT_BR = 8;

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image line of storage, one write and one read per cycle.
// The read returns the old word at the shared address (read-before-write).
module line_buffer
  import image_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: raster pixel stream to 3x3 window controller.
// Feeds an external Sobel kernel and registers its edge bit.
module sobel_stream_ctrl
  import image_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [N_SLOTS*PIX_W-1:0] win,
  input  logic                     kern_edge,
  output logic                     edge_out,
  output logic                     edge_valid,
  input  logic                     edge_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             ev_q, ev_d;
  logic             eo_q, eo_d;
  logic [PIX_W-1:0] top1_q, top2_q;
  logic [PIX_W-1:0] mid1_q, mid2_q;
  logic [PIX_W-1:0] bot1_q, bot2_q;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [N_SLOTS*PIX_W-1:0] win_raw;
  logic accept, last_col, last_row, win_on;

  assign pix_ready = (state_q == S_FILL)
                   | ((state_q == S_RUN) & (edge_ready | ~ev_q));
  assign accept    = pix_valid & pix_ready;
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_row  = (row_q == RW'(IMG_H - 1));

  // lb0 holds row r-1; lb1 is fed from lb0 and so holds row r-2
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (pix_in),
    .rdata_o (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    ev_d       = ev_q;
    eo_d       = eo_q;
    frame_done = 1'b0;
    if (ev_q && edge_ready) begin
      ev_d = 1'b0;
    end
    if (accept) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      row_d = last_col ? row_q + 1'b1 : row_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FILL: begin
        if (accept && last_col && row_q == RW'(1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept && col_q >= CW'(2)) begin
          ev_d = 1'b1;
          eo_d = kern_edge;
        end
        if (accept && last_col && last_row) begin
          state_d = S_DRAIN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_DRAIN: begin
        if (!ev_q || edge_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ev_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ev_q    <= ev_d;
      eo_q    <= eo_d;
    end
  end

  // Clearing on the last column keeps line ends out of the next line
  always_ff @(posedge clk) begin
    if (!rst_n || (accept && last_col)) begin
      top1_q <= '0;
      top2_q <= '0;
      mid1_q <= '0;
      mid2_q <= '0;
      bot1_q <= '0;
      bot2_q <= '0;
    end else if (accept) begin
      top1_q <= lb1_rd;
      top2_q <= top1_q;
      mid1_q <= lb0_rd;
      mid2_q <= mid1_q;
      bot1_q <= pix_in;
      bot2_q <= bot1_q;
    end
  end

  always_comb begin
    win_raw = '0;
    win_raw[SLOT_TL*PIX_W +: PIX_W] = top2_q;
    win_raw[SLOT_TC*PIX_W +: PIX_W] = top1_q;
    win_raw[SLOT_TR*PIX_W +: PIX_W] = lb1_rd;
    win_raw[SLOT_ML*PIX_W +: PIX_W] = mid2_q;
    win_raw[SLOT_MC*PIX_W +: PIX_W] = mid1_q;
    win_raw[SLOT_MR*PIX_W +: PIX_W] = lb0_rd;
    win_raw[SLOT_BL*PIX_W +: PIX_W] = bot2_q;
    win_raw[SLOT_BC*PIX_W +: PIX_W] = bot1_q;
    win_raw[SLOT_BR*PIX_W +: PIX_W] = pix_in;
  end

  assign win_on     = (state_q == S_FILL) || (state_q == S_RUN);
  assign win        = win_on ? win_raw : '0;
  assign edge_out   = eo_q;
  assign edge_valid = ev_q;
  assign busy       = (state_q != S_IDLE);

endmodule
